// File: rtl/adma_burst_splitter_if.sv
// adma_burst_splitter_if
//   Bundles the descriptor handshake and the AR/AW burst command channels of
//   the ADMA burst splitter.
//   Ports (signals):
//     desc_chn_i / desc_src_addr_i / desc_dst_addr_i / desc_len_i / desc_valid_i
//                                   : descriptor offered by the channel manager
//     desc_ready_o                  : splitter idle, descriptor taken on valid&ready
//     ar_chn_o / ar_addr_o / ar_len_o / ar_valid_o, ar_ready_i : read burst command
//     aw_chn_o / aw_addr_o / aw_len_o / aw_valid_o, aw_ready_i : write burst command
//     done_o / done_chn_o           : one-cycle completion pulse per descriptor
//   Modports:
//     master : the splitter itself (drives burst commands, consumes descriptors)
//     slave  : the surrounding channel manager and transaction scheduler
interface adma_burst_splitter_if #(
  parameter int DMA_CHN_NUM  = 4,
  parameter int DMA_LENGTH_W = 16,
  parameter int SRC_ADDR_W   = 32,
  parameter int DST_ADDR_W   = 32,
  parameter int ATX_LEN_W    = 8
);
  localparam int CHN_ID_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;

  logic [CHN_ID_W-1:0]     desc_chn_i;
  logic [SRC_ADDR_W-1:0]   desc_src_addr_i;
  logic [DST_ADDR_W-1:0]   desc_dst_addr_i;
  logic [DMA_LENGTH_W-1:0] desc_len_i;
  logic                    desc_valid_i;
  logic                    desc_ready_o;

  logic [CHN_ID_W-1:0]     ar_chn_o;
  logic [SRC_ADDR_W-1:0]   ar_addr_o;
  logic [ATX_LEN_W-1:0]    ar_len_o;
  logic                    ar_valid_o;
  logic                    ar_ready_i;

  logic [CHN_ID_W-1:0]     aw_chn_o;
  logic [DST_ADDR_W-1:0]   aw_addr_o;
  logic [ATX_LEN_W-1:0]    aw_len_o;
  logic                    aw_valid_o;
  logic                    aw_ready_i;

  logic                    done_o;
  logic [CHN_ID_W-1:0]     done_chn_o;

  modport master (
    input  desc_chn_i, desc_src_addr_i, desc_dst_addr_i, desc_len_i, desc_valid_i,
    output desc_ready_o,
    output ar_chn_o, ar_addr_o, ar_len_o, ar_valid_o,
    input  ar_ready_i,
    output aw_chn_o, aw_addr_o, aw_len_o, aw_valid_o,
    input  aw_ready_i,
    output done_o, done_chn_o
  );

  modport slave (
    output desc_chn_i, desc_src_addr_i, desc_dst_addr_i, desc_len_i, desc_valid_i,
    input  desc_ready_o,
    input  ar_chn_o, ar_addr_o, ar_len_o, ar_valid_o,
    output ar_ready_i,
    input  aw_chn_o, aw_addr_o, aw_len_o, aw_valid_o,
    output aw_ready_i,
    input  done_o, done_chn_o
  );
endinterface

// File: rtl/adma_burst_splitter.sv
// adma_burst_splitter
//   Takes one DMA descriptor at a time and cuts it into matched AR/AW burst
//   command pairs. Every burst is at most 2^ATX_LEN_W beats and never crosses
//   a BOUNDARY_BYTES boundary on either the source or the destination side.
//   A one-cycle done pulse marks the end of each descriptor.
//   Ports:
//     aclk    : clock
//     aresetn : asynchronous active-low reset
//     bus     : adma_burst_splitter_if.master (descriptor in, AR/AW out, done)
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | desc_ready high, waiting for a descriptor
//   ST_CALC  | size the next burst against length, AXI limit, both boundaries
//   ST_ISSUE | AR/AW valid, waiting until both sides have handshaken
//   ST_DONE  | done pulse out, back to idle next cycle
module adma_burst_splitter #(
  parameter int DMA_CHN_NUM    = 4,
  parameter int DMA_LENGTH_W   = 16,
  parameter int SRC_ADDR_W     = 32,
  parameter int DST_ADDR_W     = 32,
  parameter int ATX_DATA_W     = 256,
  parameter int ATX_LEN_W      = 8,
  parameter int BOUNDARY_BYTES = 4096
) (
  input logic                   aclk,
  input logic                   aresetn,
  adma_burst_splitter_if.master bus
);
  localparam int CHN_ID_W   = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;
  localparam int BEAT_BYTES = ATX_DATA_W / 8;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int BND_SHIFT  = $clog2(BOUNDARY_BYTES);
  localparam int OFF_W      = BND_SHIFT - BEAT_SHIFT;
  localparam int WIN_BEATS  = BOUNDARY_BYTES / BEAT_BYTES;
  // Wide enough for the remaining length, the AXI burst limit and a full window.
  localparam int CNT_W0     = (DMA_LENGTH_W > ATX_LEN_W + 1) ? DMA_LENGTH_W : ATX_LEN_W + 1;
  localparam int CNT_W      = (CNT_W0 > OFF_W + 1) ? CNT_W0 : OFF_W + 1;
  localparam logic [CNT_W-1:0] MAX_BURST = CNT_W'(2 ** ATX_LEN_W);
  localparam logic [CNT_W-1:0] WIN_CNT   = CNT_W'(WIN_BEATS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [CHN_ID_W-1:0]     chn_q;
  logic [SRC_ADDR_W-1:0]   src_q;
  logic [DST_ADDR_W-1:0]   dst_q;
  logic [DMA_LENGTH_W-1:0] rem_q;
  logic [CNT_W-1:0]        beats_q;

  logic                    ready_q;
  logic [CHN_ID_W-1:0]     ar_chn_q, aw_chn_q, done_chn_q;
  logic [SRC_ADDR_W-1:0]   ar_addr_q;
  logic [DST_ADDR_W-1:0]   aw_addr_q;
  logic [ATX_LEN_W-1:0]    ar_len_q, aw_len_q;
  logic                    ar_valid_q, aw_valid_q, done_q;

  logic [CNT_W-1:0] src_room, dst_room, beats_calc;
  logic             ar_pending, aw_pending, pair_done;

  // Room is counted in beats from the current address to the next boundary.
  always_comb begin
    src_room   = WIN_CNT - CNT_W'(src_q[BND_SHIFT-1:BEAT_SHIFT]);
    dst_room   = WIN_CNT - CNT_W'(dst_q[BND_SHIFT-1:BEAT_SHIFT]);
    beats_calc = CNT_W'(rem_q);
    if (beats_calc > MAX_BURST) beats_calc = MAX_BURST;
    if (beats_calc > src_room)  beats_calc = src_room;
    if (beats_calc > dst_room)  beats_calc = dst_room;
  end

  // A side that already handshook has its valid low and no longer blocks.
  assign ar_pending = ar_valid_q & ~bus.ar_ready_i;
  assign aw_pending = aw_valid_q & ~bus.aw_ready_i;
  assign pair_done  = ~ar_pending & ~aw_pending;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state      <= ST_IDLE;
      chn_q      <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      ready_q    <= 1'b1;
      ar_chn_q   <= '0;
      aw_chn_q   <= '0;
      ar_addr_q  <= '0;
      aw_addr_q  <= '0;
      ar_len_q   <= '0;
      aw_len_q   <= '0;
      ar_valid_q <= 1'b0;
      aw_valid_q <= 1'b0;
      done_q     <= 1'b0;
      done_chn_q <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.desc_valid_i) begin
            chn_q   <= bus.desc_chn_i;
            // Sub-beat address bits are dropped so bursts are always beat aligned.
            src_q   <= {bus.desc_src_addr_i[SRC_ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
            dst_q   <= {bus.desc_dst_addr_i[DST_ADDR_W-1:BEAT_SHIFT], {BEAT_SHIFT{1'b0}}};
            rem_q   <= bus.desc_len_i;
            ready_q <= 1'b0;
            if (bus.desc_len_i != '0) begin
              state <= ST_CALC;
            end else begin
              state      <= ST_DONE;
              done_q     <= 1'b1;
              done_chn_q <= bus.desc_chn_i;
            end
          end
        end
        ST_CALC: begin
          beats_q    <= beats_calc;
          ar_chn_q   <= chn_q;
          aw_chn_q   <= chn_q;
          ar_addr_q  <= src_q;
          aw_addr_q  <= dst_q;
          ar_len_q   <= ATX_LEN_W'(beats_calc - CNT_W'(1));
          aw_len_q   <= ATX_LEN_W'(beats_calc - CNT_W'(1));
          ar_valid_q <= 1'b1;
          aw_valid_q <= 1'b1;
          state      <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (ar_valid_q && bus.ar_ready_i) ar_valid_q <= 1'b0;
          if (aw_valid_q && bus.aw_ready_i) aw_valid_q <= 1'b0;
          if (pair_done) begin
            src_q <= src_q + (SRC_ADDR_W'(beats_q) << BEAT_SHIFT);
            dst_q <= dst_q + (DST_ADDR_W'(beats_q) << BEAT_SHIFT);
            rem_q <= rem_q - DMA_LENGTH_W'(beats_q);
            if (rem_q == DMA_LENGTH_W'(beats_q)) begin
              state      <= ST_DONE;
              done_q     <= 1'b1;
              done_chn_q <= chn_q;
            end else begin
              state <= ST_CALC;
            end
          end
        end
        ST_DONE: begin
          ready_q <= 1'b1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.desc_ready_o = ready_q;
  assign bus.ar_chn_o     = ar_chn_q;
  assign bus.ar_addr_o    = ar_addr_q;
  assign bus.ar_len_o     = ar_len_q;
  assign bus.ar_valid_o   = ar_valid_q;
  assign bus.aw_chn_o     = aw_chn_q;
  assign bus.aw_addr_o    = aw_addr_q;
  assign bus.aw_len_o     = aw_len_q;
  assign bus.aw_valid_o   = aw_valid_q;
  assign bus.done_o       = done_q;
  assign bus.done_chn_o   = done_chn_q;
endmodule

// File: tb/tb_adma_burst_splitter.sv
// tb_adma_burst_splitter
//   Self-checking bench for adma_burst_splitter. A reference model expands
//   each accepted descriptor into its expected AR/AW burst lists using plain
//   boundary arithmetic; a monitor compares every handshake, the hold rules
//   and the done pulse against it. Directed cases cover the boundary,
//   backpressure, zero-length and reset scenarios, then random descriptors
//   run with random readies.
module tb_adma_burst_splitter;
  localparam int BEAT = 32;

  logic aclk;
  logic aresetn;
  int   cyc = 0;

  adma_burst_splitter_if bus ();

  adma_burst_splitter dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    int          chn;
    logic [31:0] addr;
    int          len;
  } cmd_t;

  cmd_t ar_q[$];
  cmd_t aw_q[$];
  int   done_q[$];

  int  n_vec = 0;
  int  n_err = 0;
  int  acc_cyc = -100;
  int  acc_len = 0;
  int  last_hs_cyc = -100;
  int  last_pair_cyc = -100;
  int  ar_cnt = 0;
  int  aw_cnt = 0;
  bit  rand_rdy = 1'b0;
  bit  chk_period = 1'b0;
  bit  ar_pend = 1'b0;
  bit  aw_pend = 1'b0;
  logic [31:0] ar_addr_p, aw_addr_p;
  logic [7:0]  ar_len_p, aw_len_p;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Expected bursts: greedy split by remaining length, 256-beat limit and
  // the beats left before the next 4 KB line on each side.
  task automatic model_desc(input int chn, input logic [31:0] src, input logic [31:0] dst,
                            input int len);
    logic [31:0] s, d;
    int rem, b, sr, dr;
    s   = src & 32'hFFFF_FFE0;
    d   = dst & 32'hFFFF_FFE0;
    rem = len;
    while (rem > 0) begin
      sr = (4096 - int'(s % 4096)) / BEAT;
      dr = (4096 - int'(d % 4096)) / BEAT;
      b  = rem;
      if (b > 256) b = 256;
      if (b > sr)  b = sr;
      if (b > dr)  b = dr;
      ar_q.push_back('{chn, s, b - 1});
      aw_q.push_back('{chn, d, b - 1});
      s   = s + 32'(b * BEAT);
      d   = d + 32'(b * BEAT);
      rem = rem - b;
    end
    done_q.push_back(chn);
  endtask

  task automatic monitor();
    bit   ar_hs, aw_hs;
    cmd_t e;
    int   skew;
    if (!aresetn) return;
    if (bus.desc_valid_i && bus.desc_ready_o) begin
      model_desc(int'(bus.desc_chn_i), bus.desc_src_addr_i, bus.desc_dst_addr_i,
                 int'(bus.desc_len_i));
      acc_cyc = cyc;
      acc_len = int'(bus.desc_len_i);
    end
    if (acc_len != 0 && cyc == acc_cyc + 1)
      check_val("calc_no_valid", {bus.ar_valid_o, bus.aw_valid_o}, 2'b00);
    if (acc_len != 0 && cyc == acc_cyc + 2)
      check_val("first_valid", {bus.ar_valid_o, bus.aw_valid_o}, 2'b11);
    if (ar_pend) begin
      check_val("ar_hold_valid", bus.ar_valid_o, 1);
      check_val("ar_hold_addr", bus.ar_addr_o, ar_addr_p);
      check_val("ar_hold_len", bus.ar_len_o, ar_len_p);
    end
    if (aw_pend) begin
      check_val("aw_hold_valid", bus.aw_valid_o, 1);
      check_val("aw_hold_addr", bus.aw_addr_o, aw_addr_p);
      check_val("aw_hold_len", bus.aw_len_o, aw_len_p);
    end
    ar_hs = bus.ar_valid_o && bus.ar_ready_i;
    aw_hs = bus.aw_valid_o && bus.aw_ready_i;
    if (ar_hs) begin
      if (ar_q.size() == 0) check_val("ar_unexpected", 1, 0);
      else begin
        e = ar_q.pop_front();
        check_val("ar_chn", bus.ar_chn_o, e.chn);
        check_val("ar_addr", bus.ar_addr_o, e.addr);
        check_val("ar_len", bus.ar_len_o, e.len);
      end
      ar_cnt++;
      last_hs_cyc = cyc;
    end
    if (aw_hs) begin
      if (aw_q.size() == 0) check_val("aw_unexpected", 1, 0);
      else begin
        e = aw_q.pop_front();
        check_val("aw_chn", bus.aw_chn_o, e.chn);
        check_val("aw_addr", bus.aw_addr_o, e.addr);
        check_val("aw_len", bus.aw_len_o, e.len);
      end
      aw_cnt++;
      last_hs_cyc = cyc;
    end
    if (ar_hs || aw_hs) begin
      skew = (ar_cnt > aw_cnt) ? ar_cnt - aw_cnt : aw_cnt - ar_cnt;
      check_val("pair_skew", (skew <= 1), 1);
    end
    if (ar_hs && aw_hs) begin
      if (chk_period && last_pair_cyc > acc_cyc)
        check_val("burst_period", cyc - last_pair_cyc, 2);
      last_pair_cyc = cyc;
    end
    if (bus.done_o) begin
      if (done_q.size() == 0) check_val("done_unexpected", 1, 0);
      else check_val("done_chn", bus.done_chn_o, done_q.pop_front());
      check_val("done_pending", ar_q.size() + aw_q.size(), 0);
      check_val("done_lat", cyc - ((acc_len == 0) ? acc_cyc : last_hs_cyc), 1);
    end
    ar_pend   = bus.ar_valid_o && !bus.ar_ready_i;
    aw_pend   = bus.aw_valid_o && !bus.aw_ready_i;
    ar_addr_p = bus.ar_addr_o;
    aw_addr_p = bus.aw_addr_o;
    ar_len_p  = bus.ar_len_o;
    aw_len_p  = bus.aw_len_o;
  endtask

  task automatic sample();
    @(negedge aclk);
    monitor();
  endtask

  task automatic drive_edge();
    @(posedge aclk);
    #1;
    if (rand_rdy) begin
      bus.ar_ready_i = ($urandom_range(0, 3) != 0);
      bus.aw_ready_i = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic tick();
    sample();
    drive_edge();
  endtask

  task automatic send_desc(input int chn, input logic [31:0] src, input logic [31:0] dst,
                           input int len);
    int n;
    n = 0;
    while (!bus.desc_ready_o && n < 5000) begin
      tick();
      n++;
    end
    check_val("desc_ready_wait", bus.desc_ready_o, 1);
    bus.desc_chn_i      = 2'(chn);
    bus.desc_src_addr_i = src;
    bus.desc_dst_addr_i = dst;
    bus.desc_len_i      = 16'(len);
    bus.desc_valid_i    = 1'b1;
    tick();
    bus.desc_valid_i    = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((ar_q.size() + aw_q.size() + done_q.size() != 0 || !bus.desc_ready_o) && n < 5000) begin
      tick();
      n++;
    end
    check_val("idle_timeout", ar_q.size() + aw_q.size() + done_q.size(), 0);
  endtask

  initial begin
    aresetn             = 1'b0;
    bus.desc_chn_i      = '0;
    bus.desc_src_addr_i = '0;
    bus.desc_dst_addr_i = '0;
    bus.desc_len_i      = '0;
    bus.desc_valid_i    = 1'b0;
    bus.ar_ready_i      = 1'b0;
    bus.aw_ready_i      = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Reset state
    sample();
    check_val("rst_desc_ready", bus.desc_ready_o, 1);
    check_val("rst_valids", {bus.ar_valid_o, bus.aw_valid_o, bus.done_o}, 3'b000);
    check_val("rst_ar_addr", bus.ar_addr_o, 0);
    check_val("rst_aw_addr", bus.aw_addr_o, 0);
    check_val("rst_lens", {bus.ar_len_o, bus.aw_len_o}, 0);
    check_val("rst_chns", {bus.ar_chn_o, bus.aw_chn_o, bus.done_chn_o}, 0);
    drive_edge();

    // Readies held high: long transfer, both 4 KB limits, address wrap
    bus.ar_ready_i = 1'b1;
    bus.aw_ready_i = 1'b1;
    chk_period     = 1'b1;
    send_desc(1, 32'h0000_1000, 32'h0000_2000, 300);
    wait_idle();
    send_desc(2, 32'h0000_1FC0, 32'h0000_3000, 10);
    wait_idle();
    send_desc(3, 32'h0000_0000, 32'h0000_0FE0, 4);
    wait_idle();
    send_desc(0, 32'hFFFF_FFC0, 32'h0000_5000, 5);
    wait_idle();
    chk_period = 1'b0;

    // Skewed backpressure: AR stalled 5 cycles, AW accepts at once
    bus.ar_ready_i = 1'b0;
    bus.aw_ready_i = 1'b1;
    send_desc(2, 32'h0000_1FC0, 32'h0000_3000, 10);
    tick();
    sample();
    check_val("skew_both_valid", {bus.ar_valid_o, bus.aw_valid_o}, 2'b11);
    drive_edge();
    for (int i = 0; i < 4; i++) begin
      sample();
      check_val("skew_ar_wait", bus.ar_valid_o, 1);
      check_val("skew_aw_drop", bus.aw_valid_o, 0);
      check_val("skew_ar_addr", bus.ar_addr_o, 32'h0000_1FC0);
      check_val("skew_ar_len", bus.ar_len_o, 1);
      drive_edge();
    end
    bus.ar_ready_i = 1'b1;
    wait_idle();

    // Zero length descriptor
    send_desc(1, 32'h0000_0040, 32'h0000_0080, 0);
    sample();
    check_val("zero_done", bus.done_o, 1);
    check_val("zero_done_chn", bus.done_chn_o, 1);
    check_val("zero_no_valid", {bus.ar_valid_o, bus.aw_valid_o}, 2'b00);
    drive_edge();
    sample();
    check_val("zero_ready", bus.desc_ready_o, 1);
    check_val("zero_done_drop", bus.done_o, 0);
    check_val("zero_no_valid2", {bus.ar_valid_o, bus.aw_valid_o}, 2'b00);
    drive_edge();

    // Reset while a pair is outstanding
    bus.ar_ready_i = 1'b0;
    bus.aw_ready_i = 1'b0;
    send_desc(3, 32'h0000_8000, 32'h0000_9000, 300);
    tick();
    sample();
    check_val("rst_pre_valid", {bus.ar_valid_o, bus.aw_valid_o}, 2'b11);
    #2 aresetn = 1'b0;
    #1;
    check_val("rst_async_valid", {bus.ar_valid_o, bus.aw_valid_o}, 2'b00);
    check_val("rst_async_done", bus.done_o, 0);
    ar_q.delete();
    aw_q.delete();
    done_q.delete();
    ar_pend = 1'b0;
    aw_pend = 1'b0;
    ar_cnt  = 0;
    aw_cnt  = 0;
    drive_edge();
    drive_edge();
    aresetn = 1'b1;
    sample();
    check_val("rst_rel_ready", bus.desc_ready_o, 1);
    check_val("rst_rel_valid", {bus.ar_valid_o, bus.aw_valid_o}, 2'b00);
    drive_edge();
    bus.ar_ready_i = 1'b1;
    bus.aw_ready_i = 1'b1;
    send_desc(1, 32'h0000_1000, 32'h0000_2F00, 40);
    wait_idle();

    // Random descriptors with random readies
    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      logic [31:0] s, d;
      int l;
      s = $urandom();
      d = $urandom();
      if (k % 3 != 0) begin
        s[4:0] = 5'd0;
        d[4:0] = 5'd0;
      end
      if ($urandom_range(0, 1) == 1) s[11:5] = 7'(127 - $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) d[11:5] = 7'(127 - $urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       l = 0;
        1:       l = $urandom_range(1, 8);
        2:       l = $urandom_range(1, 300);
        default: l = $urandom_range(200, 700);
      endcase
      send_desc($urandom_range(0, 3), s, d, l);
    end
    wait_idle();
    rand_rdy = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
